// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory debug write port of the boot loader.
interface instr_loader_if #(
  parameter int unsigned XLEN = 32
);
  logic [7:0]      in_data;
  logic            in_valid;
  logic            in_ready;
  logic            dbg_wr_en;
  logic [XLEN-1:0] dbg_addr;
  logic [XLEN-1:0] dbg_instr;

  // Host side: drives the byte stream, observes the memory write port
  modport master (
    output in_data, in_valid,
    input  in_ready, dbg_wr_en, dbg_addr, dbg_instr
  );

  // Loader side
  modport slave (
    input  in_data, in_valid,
    output in_ready, dbg_wr_en, dbg_addr, dbg_instr
  );
endinterface

// File: rtl/instr_loader.sv
// Boot-time program loader: parses addr/count header from a byte stream and
// writes little-endian assembled words into instruction memory.
// Optional INSTR_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module instr_loader #(
  parameter int unsigned XLEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  instr_loader_if.slave  bus,
  output logic           cpu_hold,
  output logic           busy,
  output logic           done,
  output logic           error
);

  localparam int unsigned CNT_W = 16;
  localparam logic [XLEN:0] MEM_LIMIT = {2'b01, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_LEN   = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
`ifdef INSTR_LOADER_CHECKSUM_EN
    , S_CSUM = 3'd7
`endif
  } state_t;

`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam state_t S_FINAL = S_CSUM;
`else
  localparam state_t S_FINAL = S_DONE;
`endif

  state_t           state, state_next;
  logic [XLEN-1:0]  addr;
  logic [CNT_W-1:0] count;
  logic [1:0]       byte_idx;
  logic [XLEN-1:0]  asm_word;
  logic             fire;
  logic [CNT_W-1:0] len_next;
  logic [XLEN:0]    end_addr;
  logic             launch;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign fire     = bus.in_valid && bus.in_ready;
  assign len_next = {bus.in_data, count[7:0]};
  // Unwrapped end address of the load; must stay within the lower half.
  assign end_addr = {1'b0, addr} + (XLEN+1)'({len_next, 2'b00});
  assign launch   = (state_next == S_ADDR) && (state != S_ADDR);

  // Next-state decision
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_next = S_ADDR;
      S_ADDR: if (fire && byte_idx == 2'd3) state_next = S_LEN;
      S_LEN: begin
        if (fire && byte_idx == 2'd1) begin
          if (addr[1:0] != 2'b00)        state_next = S_ERROR;
          else if (end_addr > MEM_LIMIT) state_next = S_ERROR;
          else if (len_next == '0)       state_next = S_FINAL;
          else                           state_next = S_DATA;
        end
      end
      S_DATA: if (fire && byte_idx == 2'd3) state_next = S_WRITE;
      S_WRITE: state_next = (count > CNT_W'(1)) ? S_DATA : S_FINAL;
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CSUM: if (fire) state_next = (bus.in_data == csum) ? S_DONE : S_ERROR;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // State, datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      addr          <= '0;
      count         <= '0;
      byte_idx      <= '0;
      asm_word      <= '0;
      bus.in_ready  <= 1'b0;
      bus.dbg_wr_en <= 1'b0;
      bus.dbg_addr  <= '0;
      bus.dbg_instr <= '0;
      cpu_hold      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      state <= state_next;

      if (launch) begin
        addr     <= '0;
        count    <= '0;
        byte_idx <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum     <= '0;
`endif
      end else if (fire && state == S_ADDR) begin
        addr[{byte_idx, 3'b000} +: 8] <= bus.in_data;
        byte_idx <= byte_idx + 2'd1;
      end else if (fire && state == S_LEN) begin
        if (byte_idx == 2'd0) count[7:0]  <= bus.in_data;
        else                  count[15:8] <= bus.in_data;
        byte_idx <= (byte_idx == 2'd1) ? 2'd0 : byte_idx + 2'd1;
      end else if (fire && state == S_DATA) begin
        asm_word[{byte_idx, 3'b000} +: 8] <= bus.in_data;
        byte_idx <= byte_idx + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum     <= csum ^ bus.in_data;
`endif
      end else if (state == S_WRITE) begin
        addr  <= addr + XLEN'(4);
        count <= count - CNT_W'(1);
      end

      // Latch the write payload as the fourth byte arrives so it is stable in WRITE.
      if (state == S_DATA && state_next == S_WRITE) begin
        bus.dbg_addr  <= addr;
        bus.dbg_instr <= {bus.in_data, asm_word[XLEN-9:0]};
      end

      bus.dbg_wr_en <= (state_next == S_WRITE);
      bus.in_ready  <= (state_next == S_ADDR) || (state_next == S_LEN) ||
`ifdef INSTR_LOADER_CHECKSUM_EN
                       (state_next == S_CSUM) ||
`endif
                       (state_next == S_DATA);
      busy          <= (state_next != S_IDLE) && (state_next != S_DONE) &&
                       (state_next != S_ERROR);
      cpu_hold      <= (state_next != S_IDLE) && (state_next != S_DONE);
      done          <= (state_next == S_DONE);
      error         <= (state_next == S_ERROR);
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader; honours INSTR_LOADER_CHECKSUM_EN if defined.
module tb_instr_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, busy, done, error;

  instr_loader_if #(.XLEN(32)) bus ();

  instr_loader #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus.slave),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [7:0]  stream[$];
  logic [7:0]  full[$];
  logic [7:0]  xsum;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Capture every write strobe; the stream must be stalled while it is high
  always @(negedge clk) begin
    if (bus.dbg_wr_en === 1'b1) begin
      wa.push_back(bus.dbg_addr);
      wd.push_back(bus.dbg_instr);
      check("ready_low_in_write", 64'(bus.in_ready), 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_hdr(input logic [31:0] a, input logic [15:0] n);
    stream.delete();
    xsum = 8'h00;
    for (int i = 0; i < 4; i++) stream.push_back(a[8*i +: 8]);
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
  endtask

  task automatic push_data(input logic [7:0] b);
    stream.push_back(b);
    xsum = xsum ^ b;
  endtask

  task automatic push_tail(input logic [7:0] adj);
`ifdef INSTR_LOADER_CHECKSUM_EN
    stream.push_back(xsum ^ adj);
`else
    if (adj != 8'h00) stream.push_back(8'h00);
`endif
  endtask

  task automatic send(input int gap_max);
    for (int i = 0; i < stream.size(); i++) begin
      int  t = 0;
      bit  acc = 1'b0;
      bus.in_data  = stream[i];
      bus.in_valid = 1'b1;
      while (!acc && t < 20) begin
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk);
        #1;
        t++;
      end
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h5A;
      if (!acc) begin
        check("accept_timeout", 64'd0, 64'd1);
        return;
      end
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  task automatic wait_end();
    int t = 0;
    while (!(done || error) && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) check("end_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_basic(input int gap_max);
    push_hdr(32'h0000_0100, 16'd2);
    push_data(8'h13); push_data(8'h00); push_data(8'h00); push_data(8'h00);
    push_data(8'h93); push_data(8'h00); push_data(8'h10); push_data(8'h00);
    push_tail(8'h00);
    wa.delete(); wd.delete();
    pulse_start();
    check("basic_ready_after_start", 64'(bus.in_ready), 64'd1);
    check("basic_busy_after_start", 64'(busy), 64'd1);
    check("basic_done_cleared", 64'(done), 64'd0);
    send(gap_max);
    wait_end();
    tick();
    check("basic_nwr", 64'(wa.size()), 64'd2);
    check("basic_addr0", 64'(wa[0]), 64'h0000_0100);
    check("basic_data0", 64'(wd[0]), 64'h0000_0013);
    check("basic_addr1", 64'(wa[1]), 64'h0000_0104);
    check("basic_data1", 64'(wd[1]), 64'h0010_0093);
    check("basic_done", 64'(done), 64'd1);
    check("basic_error", 64'(error), 64'd0);
    check("basic_hold", 64'(cpu_hold), 64'd0);
    check("basic_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_wr_en", 64'(bus.dbg_wr_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hold", 64'(cpu_hold), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_addr", 64'(bus.dbg_addr), 64'd0);
    check("rst_instr", 64'(bus.dbg_instr), 64'd0);
    rst_n = 1'b1;
    tick();

    // Continuous stream, then the same stream with random gaps
    run_basic(0);
    run_basic(3);

    // Unaligned start address
    push_hdr(32'h0000_0102, 16'd1);
    wa.delete();
    pulse_start();
    send(0);
    wait_end();
    tick();
    check("unal_error", 64'(error), 64'd1);
    check("unal_done", 64'(done), 64'd0);
    check("unal_hold", 64'(cpu_hold), 64'd1);
    check("unal_ready", 64'(bus.in_ready), 64'd0);
    check("unal_nwr", 64'(wa.size()), 64'd0);

    // Last word of the lower half fits; start from ERROR clears error
    push_hdr(32'h7FFF_FFFC, 16'd1);
    push_data(8'hAA); push_data(8'hBB); push_data(8'hCC); push_data(8'hDD);
    push_tail(8'h00);
    wa.delete(); wd.delete();
    pulse_start();
    check("restart_error_clr", 64'(error), 64'd0);
    check("restart_busy", 64'(busy), 64'd1);
    send(0);
    wait_end();
    tick();
    check("top_nwr", 64'(wa.size()), 64'd1);
    check("top_addr", 64'(wa[0]), 64'h7FFF_FFFC);
    check("top_data", 64'(wd[0]), 64'hDDCC_BBAA);
    check("top_done", 64'(done), 64'd1);

    // One word past the lower half
    push_hdr(32'h7FFF_FFFC, 16'd2);
    wa.delete();
    pulse_start();
    send(0);
    wait_end();
    tick();
    check("over_error", 64'(error), 64'd1);
    check("over_nwr", 64'(wa.size()), 64'd0);

    // Header only, N=0
    push_hdr(32'h0000_0200, 16'd0);
    push_tail(8'h00);
    wa.delete();
    pulse_start();
    send(0);
    wait_end();
    tick();
    check("n0_done", 64'(done), 64'd1);
    check("n0_error", 64'(error), 64'd0);
    check("n0_nwr", 64'(wa.size()), 64'd0);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Wrong checksum byte for N=0
    push_hdr(32'h0000_0200, 16'd0);
    push_tail(8'h01);
    pulse_start();
    send(0);
    wait_end();
    tick();
    check("n0_bad_csum_error", 64'(error), 64'd1);
    check("n0_bad_csum_done", 64'(done), 64'd0);
`endif

    // Reset after two bytes of the first data word
    push_hdr(32'h0000_0400, 16'd1);
    push_data(8'h11); push_data(8'h22);
    wa.delete();
    pulse_start();
    send(0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(bus.in_ready), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_hold", 64'(cpu_hold), 64'd0);
    check("mid_rst_wr_en", 64'(bus.dbg_wr_en), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_error", 64'(error), 64'd0);
    repeat (3) tick();
    check("mid_rst_nwr", 64'(wa.size()), 64'd0);
    rst_n = 1'b1;
    tick();
    run_basic(1);

    // start pulses during DATA are ignored
    push_hdr(32'h0000_0300, 16'd2);
    push_data(8'h01); push_data(8'h02); push_data(8'h03); push_data(8'h04);
    push_data(8'h05); push_data(8'h06); push_data(8'h07); push_data(8'h08);
    push_tail(8'h00);
    full = stream;
    wa.delete(); wd.delete();
    pulse_start();
    stream = full[0:7];
    send(0);
    pulse_start();
    check("ign_start_busy", 64'(busy), 64'd1);
    stream = full[8:$];
    send(0);
    wait_end();
    tick();
    check("ign_nwr", 64'(wa.size()), 64'd2);
    check("ign_addr0", 64'(wa[0]), 64'h0000_0300);
    check("ign_data0", 64'(wd[0]), 64'h0403_0201);
    check("ign_addr1", 64'(wa[1]), 64'h0000_0304);
    check("ign_data1", 64'(wd[1]), 64'h0807_0605);
    check("ign_done", 64'(done), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "time limit");
  end
endmodule
